af_throttle_tx: RTL



---
 rtl/af_tx_pkg.sv | 17 +
 rtl/af_tx_pipe.sv | 37 +++
 rtl/af_throttle_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/af_tx_pkg.sv
// Shared types and helpers for the almost_full-throttled transmit path.
package af_tx_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Statistics counters stick at CNT_MAX instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/af_tx_pipe.sv
// Fixed-latency forward delay line: shifts every cycle, never stalls.
module af_tx_pipe #(
  parameter int DATA_WIDTH  = 512,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_valid,
  output logic [PIPE_STAGES-1:0] o_stage_vld
);

  logic [PIPE_STAGES-1:0] r_vld;
  logic [DATA_WIDTH-1:0]  r_data [PIPE_STAGES];

  // Reset empties every stage so in-flight beats are discarded at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) r_data[s] <= '0;
    end else begin
      r_vld[0]  <= i_valid;
      r_data[0] <= i_data;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_data[s] <= r_data[s-1];
      end
    end
  end

  assign o_valid     = r_vld[PIPE_STAGES-1];
  assign o_data      = r_data[PIPE_STAGES-1];
  assign o_stage_vld = r_vld;

endmodule

// File: rtl/af_throttle_tx.sv
// Producer-side throttle into a remote FIFO: almost_full with resume
// hysteresis, sticky overflow fault, and saturating statistics.
module af_throttle_tx
  import af_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int PIPE_STAGES  = 2,
  parameter int RESUME_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  ds_almost_full,
  input  logic                  ds_overflow,
  output logic                  fault,
  output logic [3:0]            inflight,
  output logic [31:0]           beats_sent,
  output logic [31:0]           stall_cycles
);

  localparam logic [7:0] RESUME_CNT = 8'(RESUME_DELAY);

  state_t                 r_state;
  logic [7:0]             r_resume_cnt;
  logic [31:0]            r_beats_cnt;
  logic [31:0]            r_stall_cnt;
  logic                   w_accept;
  logic [7:0]             w_resume_nxt;
  logic [PIPE_STAGES-1:0] w_stage_vld;
  logic [3:0]             w_inflight;

  // Combinational almost_full path so the FIFO's slack only has to cover the pipe.
  assign in_ready     = !rst && (r_state == RUN) && !ds_almost_full;
  assign w_accept     = in_valid && in_ready;
  assign w_resume_nxt = r_resume_cnt + 8'd1;

  af_tx_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .PIPE_STAGES(PIPE_STAGES)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_data     (in_data),
    .i_valid    (w_accept),
    .o_data     (out_data),
    .o_valid    (out_valid),
    .o_stage_vld(w_stage_vld)
  );

  always_comb begin
    w_inflight = '0;
    for (int s = 0; s < PIPE_STAGES; s++) w_inflight = w_inflight + {3'b000, w_stage_vld[s]};
  end

  // Overflow wins over almost_full; FAULT is left only through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_resume_cnt <= '0;
    end else if (ds_overflow) begin
      r_state <= FAULT;
    end else begin
      case (r_state)
        RUN: begin
          if (ds_almost_full) begin
            r_state      <= STALL;
            r_resume_cnt <= '0;
          end
        end
        STALL: begin
          if (ds_almost_full) begin
            r_resume_cnt <= '0;
          end else if (w_resume_nxt == RESUME_CNT) begin
            r_state      <= RUN;
            r_resume_cnt <= '0;
          end else begin
            r_resume_cnt <= w_resume_nxt;
          end
        end
        default: r_state <= FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beats_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_beats_cnt <= sat_inc(r_beats_cnt, out_valid);
      r_stall_cnt <= sat_inc(r_stall_cnt, (r_state == STALL) && in_valid);
    end
  end

  assign fault        = (r_state == FAULT);
  assign inflight     = w_inflight;
  assign beats_sent   = r_beats_cnt;
  assign stall_cycles = r_stall_cnt;

endmodule
